nibble_serial_sub: RTL and testbench
====================================

Name: nibble_serial_sub

Overview:
- Multi-cycle subtractor, the inverse-direction companion to the team's 4-bit carry-lookahead adder.
- Computes diff = a - b - bin over WIDTH bits, one 4-bit borrow-lookahead slice per clock, LSB nibble first.
- Sits in the datapath where a wide subtract is needed but area matters more than latency.
- Valid/ready handshake on both input and output; one operation in flight at a time.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived slice count; not overridden by users.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  operand presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  unsigned borrow-out (1 when a < b + bin).
- zero  output  1  diff == 0.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; in_ready=1, out_valid=0; diff, bout, zero, ovf=0; internal operand regs, borrow reg and nibble counter cleared. Reset mid-operation aborts it and produces no result.
- IDLE: in_ready=1.
  - On in_valid && in_ready, latch a, b and bin (bin into the borrow reg), clear the counter, go to RUN.
- RUN: in_ready=0, out_valid=0.
  - Each cycle, slice k = counter processes a[4k+3:4k] and b[4k+3:4k] with the borrow reg.
  - Slice equations: g = ~a & b, p = ~(a ^ b); borrows lookahead-computed, same structure as the adder.
  - Result nibble written into diff[4k+3:4k]; borrow reg updated; counter increments.
  - After slice NIBBLES-1 completes, go to DONE.
  - Results are written to diff, bout, zero and ovf on that last RUN edge.
- DONE: out_valid=1; diff, bout, zero and ovf held stable.
  - On out_ready, go to IDLE with out_valid=0 next cycle.
  - While out_ready=0, everything is held indefinitely.
- Latency: accept at edge T gives out_valid high after edge T+NIBBLES (4 cycles for WIDTH=16).
  - Minimum throughput: one result per NIBBLES+2 cycles.
- in_valid is ignored while in_ready=0. Operand inputs are don't-care outside the accept cycle.
- diff outputs are undefined-but-stable in RUN. Consumers sample only when out_valid=1.
- Flag definitions:
  - bout = final borrow reg.
  - zero = ~|diff.
  - ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the latched a and b.
- Wrap-around: the result is modulo 2^WIDTH. Borrow is reported only via bout.
- Counter width: clog2(NIBBLES), minimum 1 bit. Comparison is against NIBBLES-1.
- WIDTH=4 degenerate case: one RUN cycle; it must still work.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - the NIBBLE_W=4 constant;
  - a function returning the counter width for a given WIDTH.
- One sub-module: bla4, a combinational 4-bit borrow-lookahead subtract slice.
  - Ports: a[3:0], b[3:0], bin -> d[3:0], bout.
  - Instantiated once and time-multiplexed by the counter.

Test Plan:
- 0x1234 - 0x0234, bin=0: diff=0x1000, bout=0, zero=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge; in_ready=0 throughout.
- 0x0000 - 0x0001, bin=0: diff=0xFFFF, bout=1, zero=0, ovf=0. Borrow ripples across all four nibbles.
- 0x8000 - 0x0001: diff=0x7FFF, bout=0, ovf=1. Also 0x7FFF - 0xFFFF: diff=0x8000, bout=1, ovf=1.
- 0x5A5A - 0x5A5A with bin=0: diff=0x0000, zero=1, bout=0. Same operands with bin=1: diff=0xFFFF, bout=1, zero=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE, driving in_valid=1 with new operands. Required: out_valid and all results stable, in_ready=0, new operands not captured. After out_ready, IDLE; the next accept computes correctly.
- Assert rst_n low during the second RUN cycle. Required: out_valid=0 and in_ready=1 immediately (async), all outputs 0, no stale result after release. A following 0x0010 - 0x0001 gives 0x000F.

Source files
------------

// File: rtl/nibble_serial_sub_pkg.sv
// Shared types and helpers for the nibble-serial subtractor.
package nibble_serial_sub_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int NIBBLE_W = 4;

   // Counter width for the slice index; a single-slice design still needs one bit.
   function automatic int cnt_width(input int width);
      int n;
      n = width / NIBBLE_W;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_sub_bla4.sv
// Combinational 4-bit borrow-lookahead subtract slice: d = a - b - bin.
module nibble_serial_sub_bla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bin,
   output logic [3:0] d,
   output logic       bout
);

   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [4:0] w_c;

   // g: this bit borrows on its own; p: this bit passes an incoming borrow through.
   assign w_g = ~a & b;
   assign w_p = ~(a ^ b);

   assign w_c[0] = bin;
   assign w_c[1] = w_g[0] | (w_p[0] & bin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & bin);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bin);

   assign d    = a ^ b ^ w_c[3:0];
   assign bout = w_c[4];

endmodule

// File: rtl/nibble_serial_sub.sv
// Multi-cycle WIDTH-bit subtractor: one borrow-lookahead nibble per clock, LSB first.
module nibble_serial_sub
   import nibble_serial_sub_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int NIBBLES = WIDTH / NIBBLE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_borrow;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_zero;
   logic             r_ovf;
   logic             r_in_ready;
   logic             r_out_valid;

   logic [3:0]       w_a_nib;
   logic [3:0]       w_b_nib;
   logic [3:0]       w_d;
   logic             w_bout;
   logic [WIDTH-1:0] w_diff_nxt;

   always_comb begin
      w_a_nib = '0;
      w_b_nib = '0;
      for (int k = 0; k < NIBBLES; k++) begin
         if (r_cnt == CW'(k)) begin
            w_a_nib = r_a[k*NIBBLE_W +: NIBBLE_W];
            w_b_nib = r_b[k*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   nibble_serial_sub_bla4 u_bla4 (
      .a    (w_a_nib),
      .b    (w_b_nib),
      .bin  (r_borrow),
      .d    (w_d),
      .bout (w_bout)
   );

   // Full result as it will look after this slice lands; the flags need it on the last edge.
   always_comb begin
      w_diff_nxt = r_diff;
      for (int k = 0; k < NIBBLES; k++) begin
         if (r_cnt == CW'(k)) w_diff_nxt[k*NIBBLE_W +: NIBBLE_W] = w_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_borrow    <= 1'b0;
         r_cnt       <= '0;
         r_diff      <= '0;
         r_bout      <= 1'b0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a        <= a;
                  r_b        <= b;
                  r_borrow   <= bin;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               r_diff   <= w_diff_nxt;
               r_borrow <= w_bout;
               r_cnt    <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_bout      <= w_bout;
                  r_zero      <= ~|w_diff_nxt;
                  r_ovf       <= (r_a[WIDTH-1] ^ r_b[WIDTH-1])
                               & (w_diff_nxt[WIDTH-1] ^ r_a[WIDTH-1]);
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign diff      = r_diff;
   assign bout      = r_bout;
   assign zero      = r_zero;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Scoreboard bench for nibble_serial_sub (WIDTH=16): latency, flags, backpressure, async reset.
module tb_nibble_serial_sub;

   localparam int W   = 16;
   localparam int LAT = 4;
   localparam int TMO = 20;

   typedef struct {
      logic [W-1:0] diff;
      logic         bout;
      logic         zero;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] diff;
   logic         bout;
   logic         zero;
   logic         ovf;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   nibble_serial_sub #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
   );

   // Reference from plain 17-bit arithmetic; pushed when the operands are driven.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      exp_t e;
      logic [W:0] r;
      r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
      e.diff = r[W-1:0];
      e.bout = r[W];
      e.zero = (r[W-1:0] == '0);
      e.ovf  = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      return e;
   endfunction

   // Presents one operation for exactly one edge; returns #1 after the accept edge.
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      sb.push_back(model(x, y, c));
      a = x; b = y; bin = c; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
   endtask

   // Counts edges until out_valid; n = TMO means it never arrived.
   task automatic wait_out(output int n, output int rdy_seen);
      n = 0; rdy_seen = 0;
      while (!out_valid && n < TMO) begin
         if (in_ready) rdy_seen++;
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      checks++;
      if ({in_ready, out_valid, diff, bout, zero, ovf} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
         errors++;
         $display("FAIL reset: rdy=%b vld=%b diff=%h bout=%b zero=%b ovf=%b required rdy=1 vld=0 rest 0",
                  in_ready, out_valid, diff, bout, zero, ovf);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_vectors;
      logic [W-1:0] va [6] = '{16'h1234, 16'h0000, 16'h8000, 16'h7FFF, 16'h5A5A, 16'h5A5A};
      logic [W-1:0] vb [6] = '{16'h0234, 16'h0001, 16'h0001, 16'hFFFF, 16'h5A5A, 16'h5A5A};
      logic         vc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int n, rdy;
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         send(va[i], vb[i], vc[i]);
         wait_out(n, rdy);
         checks++;
         if (n != LAT || rdy != 0) begin
            errors++;
            $display("FAIL latency[%0d]: edges=%0d in_ready_seen=%0d required edges=%0d in_ready_seen=0",
                     i, n, rdy, LAT);
         end
         if (n < TMO) begin
            e = sb.pop_front();
            checks++;
            if ({diff, bout, zero, ovf} !== {e.diff, e.bout, e.zero, e.ovf}) begin
               errors++;
               $display("FAIL vec[%0d] %h-%h-%b: diff=%h bout=%b zero=%b ovf=%b required diff=%h bout=%b zero=%b ovf=%b",
                        i, va[i], vb[i], vc[i], diff, bout, zero, ovf, e.diff, e.bout, e.zero, e.ovf);
            end
         end else sb.delete();
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release[%0d]: vld=%b rdy=%b required vld=0 rdy=1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_backpressure;
      int n, rdy;
      exp_t e;
      out_ready = 1'b0;
      send(16'hC0DE, 16'h1111, 1'b1);
      wait_out(n, rdy);
      e = sb.pop_front();
      checks++;
      if (n >= TMO || {diff, bout, zero, ovf} !== {e.diff, e.bout, e.zero, e.ovf}) begin
         errors++;
         $display("FAIL bp_result: edges=%0d diff=%h bout=%b required diff=%h bout=%b",
                  n, diff, bout, e.diff, e.bout);
      end
      a = 16'h0F0F; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
             {diff, bout, zero, ovf} !== {e.diff, e.bout, e.zero, e.ovf}) begin
            errors++;
            $display("FAIL bp_hold[%0d]: vld=%b rdy=%b diff=%h required vld=1 rdy=0 diff=%h",
                     i, out_valid, in_ready, diff, e.diff);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
      end
      // Stay idle a few cycles: a captured stray operand would show up as a result here.
      repeat (LAT + 2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_no_capture: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
      end
      send(16'h0100, 16'h0001, 1'b0);
      wait_out(n, rdy);
      e = sb.pop_front();
      checks++;
      if (n != LAT || {diff, bout, zero, ovf} !== {e.diff, e.bout, e.zero, e.ovf}) begin
         errors++;
         $display("FAIL bp_next: edges=%0d diff=%h required edges=%0d diff=%h", n, diff, LAT, e.diff);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midrun;
      int n, rdy;
      exp_t e;
      send(16'hFFFF, 16'h1234, 1'b1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, diff, bout, zero, ovf} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
         errors++;
         $display("FAIL midrun_reset: rdy=%b vld=%b diff=%h bout=%b zero=%b ovf=%b required rdy=1 vld=0 rest 0",
                  in_ready, out_valid, diff, bout, zero, ovf);
      end
      sb.delete();
      @(negedge clk); rst_n = 1'b1;
      rdy = 0;
      for (int i = 0; i < LAT + 3; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) rdy++;
      end
      checks++;
      if (rdy != 0) begin
         errors++;
         $display("FAIL midrun_stale: out_valid high %0d cycles required 0", rdy);
      end
      send(16'h0010, 16'h0001, 1'b0);
      wait_out(n, rdy);
      e = sb.pop_front();
      checks++;
      if (n != LAT || diff !== 16'h000F || {diff, bout, zero, ovf} !== {e.diff, e.bout, e.zero, e.ovf}) begin
         errors++;
         $display("FAIL midrun_after: edges=%0d diff=%h bout=%b required edges=%0d diff=000f bout=0",
                  n, diff, bout, LAT);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int n, rdy;
      exp_t e;
      logic [W-1:0] x, y;
      logic c;
      for (int i = 0; i < 10; i++) begin
         x = W'($urandom); y = W'($urandom); c = 1'($urandom);
         send(x, y, c);
         wait_out(n, rdy);
         checks++;
         if (n >= TMO) begin
            errors++;
            $display("FAIL b2b_timeout[%0d]: no out_valid within %0d edges", i, TMO);
            sb.delete();
         end else begin
            e = sb.pop_front();
            if ({diff, bout, zero, ovf} !== {e.diff, e.bout, e.zero, e.ovf}) begin
               errors++;
               $display("FAIL b2b[%0d] %h-%h-%b: diff=%h bout=%b zero=%b ovf=%b required diff=%h bout=%b zero=%b ovf=%b",
                        i, x, y, c, diff, bout, zero, ovf, e.diff, e.bout, e.zero, e.ovf);
            end
         end
         // Re-present immediately on the first idle cycle for minimum spacing.
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset;
      test_vectors;
      test_backpressure;
      test_reset_midrun;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
